// File: rtl/accel_mem_port.sv
// Accelerator-to-CPU memory port bridge: write FIFO, one outstanding read, single-port arbiter.
// Build option ACCEL_PORT_RD_PRIORITY_EN: a pending read wins IDLE arbitration unless the hazard rule forces a write.
module accel_mem_port #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CL_WIDTH      = 512,
  parameter int unsigned WR_FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_CYC   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc_wr_req,
  input  logic [ADDR_WIDTH-1:0] acc_wr_addr,
  input  logic [DATA_WIDTH-1:0] acc_wr_data,
  output logic                  acc_wr_full,
  output logic                  acc_wr_done,
  input  logic                  acc_rd_req,
  input  logic [ADDR_WIDTH-1:0] acc_rd_addr,
  output logic                  acc_rd_busy,
  output logic                  acc_rd_valid,
  output logic [CL_WIDTH-1:0]   acc_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wrt_data,
  output logic                  mem_wrt_en,
  output logic                  mem_rd_en,
  input  logic                  mem_wrt_ack,
  input  logic                  mem_rd_ack,
  input  logic [CL_WIDTH-1:0]   mem_rd_data,
  output logic [1:0]            err
);
  localparam int unsigned PW = $clog2(WR_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] fifo_addr [WR_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WR_FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            tcnt;
  logic                  push, pop, rd_fin, tmo, hazard, wr_pend, pick_wr;

  assign acc_wr_full = (count == (PW+1)'(WR_FIFO_DEPTH));
  assign push        = acc_wr_req & ~acc_wr_full;
  assign wr_pend     = (count != '0);
  assign tmo         = (tcnt == 8'(TIMEOUT_CYC - 1));
  assign pop         = (state == WR) && (mem_wrt_ack || tmo);
  assign rd_fin      = (state == RD) && (mem_rd_ack || tmo);

  // Read-after-write hazard: the pending read address matches any occupied FIFO slot.
  always_comb begin
    logic [PW-1:0] idx;
    logic [PW-1:0] off;
    hazard = 1'b0;
    idx    = '0;
    off    = '0;
    for (int unsigned i = 0; i < WR_FIFO_DEPTH; i++) begin
      idx = PW'(i);
      off = idx - rd_ptr;
      if (({1'b0, off} < count) && (fifo_addr[idx] == rd_addr)) hazard = 1'b1;
    end
    hazard = hazard & acc_rd_busy;
  end

`ifdef ACCEL_PORT_RD_PRIORITY_EN
  assign pick_wr = wr_pend && (!acc_rd_busy || hazard);
`else
  logic rr_last_rd;
  assign pick_wr = wr_pend && (!acc_rd_busy || hazard || rr_last_rd);
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= acc_wr_addr;
      fifo_data[wr_ptr] <= acc_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Completion (or timeout) has priority, so a new read is only taken once busy has dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_rd_busy <= 1'b0;
      rd_addr     <= '0;
    end else if (rd_fin) begin
      acc_rd_busy <= 1'b0;
    end else if (acc_rd_req && !acc_rd_busy) begin
      acc_rd_busy <= 1'b1;
      rd_addr     <= acc_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_addr     <= '0;
      mem_wrt_data <= '0;
      mem_wrt_en   <= 1'b0;
      mem_rd_en    <= 1'b0;
      acc_wr_done  <= 1'b0;
      acc_rd_valid <= 1'b0;
      acc_rd_data  <= '0;
      tcnt         <= '0;
      err          <= '0;
`ifndef ACCEL_PORT_RD_PRIORITY_EN
      rr_last_rd   <= 1'b1;
`endif
    end else begin
      acc_wr_done  <= 1'b0;
      acc_rd_valid <= 1'b0;
      if (acc_wr_req && acc_wr_full) err[0] <= 1'b1;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (pick_wr) begin
            state        <= WR;
            mem_wrt_en   <= 1'b1;
            mem_addr     <= fifo_addr[rd_ptr];
            mem_wrt_data <= fifo_data[rd_ptr];
          end else if (acc_rd_busy) begin
            state     <= RD;
            mem_rd_en <= 1'b1;
            mem_addr  <= rd_addr;
          end
        end
        WR: begin
          if (mem_wrt_ack) begin
            state       <= IDLE;
            mem_wrt_en  <= 1'b0;
            acc_wr_done <= 1'b1;
            tcnt        <= '0;
`ifndef ACCEL_PORT_RD_PRIORITY_EN
            rr_last_rd  <= 1'b0;
`endif
          end else if (tmo) begin
            state      <= IDLE;
            mem_wrt_en <= 1'b0;
            err[1]     <= 1'b1;
            tcnt       <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RD: begin
          if (mem_rd_ack) begin
            state        <= IDLE;
            mem_rd_en    <= 1'b0;
            acc_rd_valid <= 1'b1;
            acc_rd_data  <= mem_rd_data;
            tcnt         <= '0;
`ifndef ACCEL_PORT_RD_PRIORITY_EN
            rr_last_rd   <= 1'b1;
`endif
          end else if (tmo) begin
            state     <= IDLE;
            mem_rd_en <= 1'b0;
            err[1]    <= 1'b1;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          mem_wrt_en <= 1'b0;
          mem_rd_en  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accel_mem_port.sv
// Self-checking bench for accel_mem_port: directed scenarios plus a randomized transaction-level scoreboard.
module tb_accel_mem_port;
  localparam int unsigned AW = 16, DW = 32, CW = 512, DEPTH = 4;

  logic          clk = 1'b0, rst_n;
  logic          acc_wr_req, acc_wr_full, acc_wr_done;
  logic [AW-1:0] acc_wr_addr, acc_rd_addr, mem_addr;
  logic [DW-1:0] acc_wr_data, mem_wrt_data;
  logic          acc_rd_req, acc_rd_busy, acc_rd_valid;
  logic [CW-1:0] acc_rd_data, mem_rd_data;
  logic          mem_wrt_en, mem_rd_en, mem_wrt_ack, mem_rd_ack;
  logic [1:0]    err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            tag;
  } wr_t;

  always #5 clk = ~clk;

  accel_mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CL_WIDTH(CW),
                   .WR_FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_wr_req(acc_wr_req), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
    .acc_wr_full(acc_wr_full), .acc_wr_done(acc_wr_done),
    .acc_rd_req(acc_rd_req), .acc_rd_addr(acc_rd_addr), .acc_rd_busy(acc_rd_busy),
    .acc_rd_valid(acc_rd_valid), .acc_rd_data(acc_rd_data),
    .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en),
    .mem_rd_en(mem_rd_en), .mem_wrt_ack(mem_wrt_ack), .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    acc_wr_req  = 1'b0;
    acc_wr_addr = '0;
    acc_wr_data = '0;
    acc_rd_req  = 1'b0;
    acc_rd_addr = '0;
    mem_wrt_ack = 1'b0;
    mem_rd_ack  = 1'b0;
    mem_rd_data = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({mem_wrt_en, mem_rd_en, acc_wr_full, acc_wr_done, acc_rd_busy, acc_rd_valid, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {mem_wrt_en, mem_rd_en, acc_wr_full, acc_wr_done, acc_rd_busy, acc_rd_valid, err});
    end
    checks++;
    if ({mem_addr, mem_wrt_data} !== '0) begin
      errors++;
      $display("FAIL reset_addr_data: got %h/%h expected 0/0", mem_addr, mem_wrt_data);
    end
    checks++;
    if (acc_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h expected 0", acc_rd_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    acc_wr_req = 1'b1; acc_wr_addr = 16'h0010; acc_wr_data = 32'hDEADBEEF;
    tick();
    acc_wr_req = 1'b0;
    checks++;
    if (mem_wrt_en !== 1'b0) begin
      errors++; $display("FAIL sw_en_early: got %b expected 0", mem_wrt_en);
    end
    tick();
    checks++;
    if ({mem_wrt_en, mem_addr, mem_wrt_data} !== {1'b1, 16'h0010, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw_request: got en=%b a=%h d=%h expected en=1 a=0010 d=deadbeef",
               mem_wrt_en, mem_addr, mem_wrt_data);
    end
    mem_wrt_ack = 1'b1;
    tick();
    mem_wrt_ack = 1'b0;
    checks++;
    if ({mem_wrt_en, acc_wr_done} !== 2'b01) begin
      errors++; $display("FAIL sw_done: got en,done=%b expected 01", {mem_wrt_en, acc_wr_done});
    end
    tick();
    checks++;
    if (acc_wr_done !== 1'b0) begin
      errors++; $display("FAIL sw_done_pulse: got %b expected 0", acc_wr_done);
    end
  endtask

  task automatic test_fifo_full();
    int n_done = 0;
    int n_ack  = 0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      acc_wr_req  = 1'b1;
      acc_wr_addr = AW'(32'h100 + k);
      acc_wr_data = DW'(32'hC000 + k);
      tick();
      checks++;
      if (acc_wr_full !== (k >= 3)) begin
        errors++; $display("FAIL full_after_push%0d: got %b expected %b", k, acc_wr_full, (k >= 3));
      end
    end
    acc_wr_req = 1'b0;
    checks++;
    if (err !== 2'b01) begin
      errors++; $display("FAIL full_err: got %b expected 01", err);
    end
    for (int c = 0; c < 80; c++) begin
      if (acc_wr_done) n_done++;
      if (mem_wrt_en) begin
        checks++;
        if ({mem_addr, mem_wrt_data} !== {AW'(32'h100 + n_ack), DW'(32'hC000 + n_ack)}) begin
          errors++;
          $display("FAIL full_order%0d: got %h/%h expected %h/%h", n_ack, mem_addr, mem_wrt_data,
                   AW'(32'h100 + n_ack), DW'(32'hC000 + n_ack));
        end
        n_ack++;
      end
      mem_wrt_ack = mem_wrt_en;
      tick();
    end
    mem_wrt_ack = 1'b0;
    checks++;
    if (n_done != 4) begin
      errors++; $display("FAIL full_done_count: got %0d expected 4", n_done);
    end
    checks++;
    if (acc_wr_full !== 1'b0) begin
      errors++; $display("FAIL full_drained: got %b expected 0", acc_wr_full);
    end
  endtask

  task automatic test_hazard();
    logic [CW-1:0] line_a5;
    byte           order[$];
    logic [AW-1:0] oaddr[$];
    logic          got_valid = 1'b0;
    int            n_done = 0;
    line_a5 = {64{8'hA5}};
    do_reset();
    acc_wr_req = 1'b1; acc_wr_addr = 16'h0500; acc_wr_data = 32'h1;
    tick();
    acc_wr_req = 1'b0;
    for (int c = 0; c < 20 && n_done == 0; c++) begin
      if (acc_wr_done) n_done++;
      mem_wrt_ack = mem_wrt_en;
      if (n_done == 0) tick();
    end
    mem_wrt_ack = 1'b0;
    acc_wr_req = 1'b1; acc_wr_addr = 16'h0020; acc_wr_data = 32'h12345678;
    acc_rd_req = 1'b1; acc_rd_addr = 16'h0020;
    tick();
    acc_wr_req = 1'b0; acc_rd_req = 1'b0;
    for (int c = 0; c < 40 && !got_valid; c++) begin
      if (acc_rd_valid) begin
        got_valid = 1'b1;
        checks++;
        if ({acc_rd_busy, acc_rd_data} !== {1'b0, line_a5}) begin
          errors++; $display("FAIL hz_rd_data: got busy=%b data=%h expected busy=0 data=%h",
                             acc_rd_busy, acc_rd_data, line_a5);
        end
      end
      mem_wrt_ack = mem_wrt_en;
      mem_rd_ack  = mem_rd_en;
      mem_rd_data = mem_rd_en ? line_a5 : '0;
      if (mem_wrt_en) begin order.push_back(8'h57); oaddr.push_back(mem_addr); end
      if (mem_rd_en)  begin order.push_back(8'h52); oaddr.push_back(mem_addr); end
      if (!got_valid) tick();
    end
    drive_idle();
    checks++;
    if (!got_valid || order.size() != 2) begin
      errors++; $display("FAIL hz_complete: valid=%b issued=%0d expected valid=1 issued=2", got_valid, order.size());
    end else begin
      checks++;
      if ({order[0], oaddr[0], order[1], oaddr[1]} !== {8'h57, 16'h0020, 8'h52, 16'h0020}) begin
        errors++; $display("FAIL hz_order: got %c@%h,%c@%h expected W@0020,R@0020",
                           order[0], oaddr[0], order[1], oaddr[1]);
      end
    end
  endtask

  task automatic test_alternate();
    byte order[$];
    byte exp_ord[4];
    logic pw = 1'b0, pr = 1'b0;
`ifdef ACCEL_PORT_RD_PRIORITY_EN
    exp_ord = '{8'h52, 8'h57, 8'h52, 8'h57};
`else
    exp_ord = '{8'h57, 8'h52, 8'h57, 8'h52};
`endif
    do_reset();
    acc_wr_req = 1'b1; acc_wr_addr = 16'h0030; acc_wr_data = 32'hAAAA0030;
    acc_rd_req = 1'b1; acc_rd_addr = 16'h0040;
    for (int c = 0; c < 100 && order.size() < 4; c++) begin
      if (mem_wrt_en && !pw) order.push_back(8'h57);
      if (mem_rd_en && !pr)  order.push_back(8'h52);
      pw = mem_wrt_en; pr = mem_rd_en;
      mem_wrt_ack = mem_wrt_en;
      mem_rd_ack  = mem_rd_en;
      tick();
    end
    drive_idle();
    checks++;
    if (order.size() < 4) begin
      errors++; $display("FAIL alt_issue_count: got %0d expected 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] !== exp_ord[i]) begin
          errors++; $display("FAIL alt_order%0d: got %c expected %c", i, order[i], exp_ord[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int   n_en = 0;
    logic seen_valid = 1'b0;
    logic dropped = 1'b0;
    do_reset();
    acc_rd_req = 1'b1; acc_rd_addr = 16'h0050;
    tick();
    acc_rd_req = 1'b0;
    for (int c = 0; c < 400 && !dropped; c++) begin
      tick();
      if (mem_rd_en) n_en++;
      if (acc_rd_valid) seen_valid = 1'b1;
      if (n_en > 0 && !mem_rd_en) dropped = 1'b1;
    end
    repeat (3) begin
      tick();
      if (acc_rd_valid) seen_valid = 1'b1;
    end
    checks++;
    if (!dropped || n_en != 255) begin
      errors++; $display("FAIL to_cycles: dropped=%b en_cycles=%0d expected dropped=1 en_cycles=255", dropped, n_en);
    end
    checks++;
    if ({err, acc_rd_busy, seen_valid} !== 4'b1000) begin
      errors++; $display("FAIL to_status: got err=%b busy=%b valid_seen=%b expected err=10 busy=0 valid_seen=0",
                         err, acc_rd_busy, seen_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_en = 1'b0, seen_done = 1'b0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      acc_wr_req = 1'b1; acc_wr_addr = AW'(32'h60 + k); acc_wr_data = DW'(k);
      tick();
    end
    acc_wr_req = 1'b0;
    for (int c = 0; c < 10 && !seen_en; c++) begin
      if (mem_wrt_en) seen_en = 1'b1;
      else tick();
    end
    checks++;
    if (!seen_en) begin
      errors++; $display("FAIL rm_setup: got en=0 expected en=1");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_wrt_en, mem_rd_en, acc_wr_full, acc_wr_done, acc_rd_busy, acc_rd_valid, err, mem_addr, mem_wrt_data} !== '0) begin
      errors++; $display("FAIL rm_outputs: got en=%b a=%h d=%h expected all zero", mem_wrt_en, mem_addr, mem_wrt_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_wrt_ack = 1'b1;
    seen_en = 1'b0;
    repeat (20) begin
      tick();
      if (mem_wrt_en) seen_en = 1'b1;
      if (acc_wr_done) seen_done = 1'b1;
    end
    mem_wrt_ack = 1'b0;
    checks++;
    if ({seen_en, seen_done, acc_wr_full} !== 3'b000) begin
      errors++; $display("FAIL rm_after: got en_seen=%b done_seen=%b full=%b expected 000", seen_en, seen_done, acc_wr_full);
    end
  endtask

  task automatic test_random();
    wr_t           q[$];
    logic          busy_m = 1'b0, exp_done = 1'b0, exp_valid = 1'b0, full_before, hit;
    logic          prev_w = 1'b0, prev_r = 1'b0, drain;
    logic [AW-1:0] raddr_m = '0, prev_a = '0;
    logic [DW-1:0] prev_d = '0;
    logic [CW-1:0] exp_line = '0, line;
    int            cyc = 0;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      drain = (c >= 600);
      checks++;
      if (acc_wr_full !== (q.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_full c=%0d: got %b expected %b", c, acc_wr_full, (q.size() == DEPTH));
      end
      checks++;
      if ({acc_rd_busy, acc_wr_done, acc_rd_valid} !== {busy_m, exp_done, exp_valid}) begin
        errors++; $display("FAIL rnd_status c=%0d: got busy,done,valid=%b expected %b", c,
                           {acc_rd_busy, acc_wr_done, acc_rd_valid}, {busy_m, exp_done, exp_valid});
      end
      if (exp_valid) begin
        checks++;
        if (acc_rd_data !== exp_line) begin
          errors++; $display("FAIL rnd_rd_data c=%0d: got %h expected %h", c, acc_rd_data, exp_line);
        end
      end
      checks++;
      if (mem_wrt_en && mem_rd_en) begin
        errors++; $display("FAIL rnd_exclusive c=%0d: got both enables 1 expected at most one", c);
      end
      if (mem_wrt_en && prev_w) begin
        checks++;
        if ({mem_addr, mem_wrt_data} !== {prev_a, prev_d}) begin
          errors++; $display("FAIL rnd_wr_stable c=%0d: got %h/%h expected %h/%h", c, mem_addr, mem_wrt_data, prev_a, prev_d);
        end
      end
      if (mem_rd_en && prev_r) begin
        checks++;
        if (mem_addr !== prev_a) begin
          errors++; $display("FAIL rnd_rd_stable c=%0d: got %h expected %h", c, mem_addr, prev_a);
        end
      end
      if (mem_rd_en && !prev_r) begin
        hit = 1'b0;
        foreach (q[i]) if (q[i].a == mem_addr && q[i].tag < cyc) hit = 1'b1;
        checks++;
        if (hit || mem_addr !== raddr_m) begin
          errors++; $display("FAIL rnd_rd_issue c=%0d: got addr=%h hazard=%b expected addr=%h hazard=0", c, mem_addr, hit, raddr_m);
        end
      end
      prev_w = mem_wrt_en; prev_r = mem_rd_en; prev_a = mem_addr; prev_d = mem_wrt_data;

      acc_wr_req  = !drain && ($urandom_range(0, 1) == 1);
      acc_wr_addr = AW'($urandom_range(0, 7));
      acc_wr_data = $urandom;
      acc_rd_req  = !drain && ($urandom_range(0, 3) == 0);
      acc_rd_addr = AW'($urandom_range(0, 7));
      mem_wrt_ack = mem_wrt_en && (drain || $urandom_range(0, 1) == 1);
      mem_rd_ack  = mem_rd_en && (drain || $urandom_range(0, 1) == 1);
      for (int k = 0; k < CW / 32; k++) line[k*32 +: 32] = $urandom;
      mem_rd_data = line;

      full_before = (q.size() == DEPTH);
      exp_done  = 1'b0;
      exp_valid = 1'b0;
      if (mem_wrt_ack) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_wr_head c=%0d: got write %h/%h expected no write pending", c, mem_addr, mem_wrt_data);
        end else begin
          if ({mem_addr, mem_wrt_data} !== {q[0].a, q[0].d}) begin
            errors++; $display("FAIL rnd_wr_head c=%0d: got %h/%h expected %h/%h", c, mem_addr, mem_wrt_data, q[0].a, q[0].d);
          end
          void'(q.pop_front());
        end
        exp_done = 1'b1;
      end
      if (mem_rd_ack) begin
        exp_valid = 1'b1;
        exp_line  = line;
        busy_m    = 1'b0;
      end else if (acc_rd_req && !busy_m) begin
        busy_m  = 1'b1;
        raddr_m = acc_rd_addr;
      end
      if (acc_wr_req && !full_before) q.push_back('{acc_wr_addr, acc_wr_data, cyc + 1});
      tick();
      cyc++;
    end
    drive_idle();
    checks++;
    if ({q.size() == 0, busy_m, err[1]} !== 3'b100) begin
      errors++; $display("FAIL rnd_final: got q_empty=%b busy=%b err1=%b expected 1,0,0", q.size() == 0, busy_m, err[1]);
    end
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    test_single_write();
    test_fifo_full();
    test_hazard();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
